// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, word size and request error-cause classification.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [2:0] ERR_NONE  = 3'b000;
  localparam logic [2:0] ERR_RANGE = 3'b001;
  localparam logic [2:0] ERR_ALIGN = 3'b010;
  localparam logic [2:0] ERR_BE    = 3'b100;

  // off is the base-relative offset (wrapped), so addresses below the base land out of range
  function automatic logic [2:0] err_cause(input logic [31:0] off, input logic [1:0] addr_lo,
                                           input logic [3:0] be, input logic [31:0] limit);
    logic [2:0] cause;
    cause = ERR_NONE;
    if (off >= limit) cause = cause | ERR_RANGE;
    if (addr_lo != 2'b00) cause = cause | ERR_ALIGN;
    if (be == 4'b0000) cause = cause | ERR_BE;
    return cause;
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-lane merge for partial stores: enabled lanes take the store data,
// the rest keep the old memory word.
module dm_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) new_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: single outstanding valid/ready request, fixed wait latency,
// held response and a one-cycle write-log pulse for committed stores.
module dm_responder #(
  parameter int unsigned DEPTH     = 3072,
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);
  import dm_pkg::*;

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * WORD_BYTES);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  dm_state_e   state_q;
  logic [3:0]  cnt_q;
  logic        lat_we_q;
  logic [3:0]  lat_be_q;
  logic [31:0] lat_addr_q, lat_wdata_q, lat_pc_q;
  logic        req_ready_q, resp_valid_q, resp_err_q, log_valid_q;
  logic [31:0] resp_rdata_q, log_pc_q, log_addr_q, log_data_q;
  logic [31:0] mem [DEPTH];

  logic        accept, enter_resp;
  logic        a_we, a_err;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_pc, off, old_word, new_word;
  logic [2:0]  cause;
  logic [IDX_W-1:0] idx;

  assign accept = req_valid && req_ready_q;

  // With zero latency the access happens on the accept edge, straight from the inputs
  always_comb begin
    a_we    = lat_we_q;
    a_be    = lat_be_q;
    a_addr  = lat_addr_q;
    a_wdata = lat_wdata_q;
    a_pc    = lat_pc_q;
    if (state_q == ST_IDLE) begin
      a_we    = req_we;
      a_be    = req_be;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_pc    = req_pc;
    end
  end

  assign off      = a_addr - ADDR_BASE;
  assign idx      = off[IDX_W+1:2];
  assign cause    = err_cause(off, a_addr[1:0], a_be, LIMIT);
  assign a_err    = (cause != ERR_NONE);
  assign old_word = a_err ? 32'h0 : mem[idx];

  assign enter_resp = (accept && (LATENCY == 0)) || (state_q == ST_WAIT && cnt_q == 4'd1);

  dm_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (a_wdata),
    .be       (a_be),
    .new_word (new_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      lat_we_q     <= 1'b0;
      lat_be_q     <= 4'd0;
      lat_addr_q   <= 32'h0;
      lat_wdata_q  <= 32'h0;
      lat_pc_q     <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      log_valid_q  <= 1'b0;
      log_pc_q     <= 32'h0;
      log_addr_q   <= 32'h0;
      log_data_q   <= 32'h0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
    end else begin
      log_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            lat_we_q    <= req_we;
            lat_be_q    <= req_be;
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
            lat_pc_q    <= req_pc;
            cnt_q       <= LAT;
            req_ready_q <= 1'b0;
            state_q     <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= a_err;
        resp_rdata_q <= (a_we || a_err) ? 32'h0 : old_word;
        if (a_we && !a_err) begin
          mem[idx]    <= new_word;
          log_valid_q <= 1'b1;
          log_pc_q    <= a_pc;
          log_addr_q  <= a_addr;
          log_data_q  <= new_word;
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign log_valid  = log_valid_q;
  assign log_pc     = log_pc_q;
  assign log_addr   = log_addr_q;
  assign log_data   = log_data_q;

endmodule
